// File: rtl/tt_ternary_pkg.sv
// Shared types and the chip's counter rule for the ternary accelerator host side.
package tt_ternary_pkg;

  typedef enum logic [2:0] {IDLE, RSTC, LOAD, MULT, DRAIN} state_t;

  localparam int LOAD_WORDS = 14;
  localparam int ROWS       = 7;

  // Result tag carried alongside the chip's pipeline latency.
  typedef struct packed {
    logic       v;
    logic [2:0] row;
  } tag_t;

  // Chip free-running count: 0..6, 8..14, 0, ... (skips x7 and xF).
  function automatic logic [3:0] next_cnt(input logic [3:0] c);
    return (c[2:0] == 3'd6) ? c + 4'd2 : c + 4'd1;
  endfunction

endpackage

// File: rtl/tt_ternary_frame_buf.sv
// Ping-pong vector frame buffer: one bank fills while the other is read out.
module tt_ternary_frame_buf
  import tt_ternary_pkg::*;
#(
  parameter int DEPTH = ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  logic        v_valid,
  output logic        v_ready,
  input  logic [15:0] v_data,
  input  logic [2:0]  rd_idx,
  output logic [15:0] rd_data,
  output logic        frame_avail,
  input  logic        pop_frame
);

  logic [15:0] mem [2][DEPTH];
  logic [1:0]  full;
  logic        wr_bank, rd_bank;
  logic [2:0]  wcnt;
  logic        wr;

  assign v_ready     = wr_en && !full[wr_bank];
  assign wr          = v_valid && v_ready;
  assign frame_avail = full[rd_bank];
  assign rd_data     = mem[rd_bank][rd_idx];

  // Bank bookkeeping; a bank being written is never full, so fill and pop never collide.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wcnt    <= '0;
    end else begin
      if (pop_frame && full[rd_bank]) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (wr) begin
        if (wcnt == 3'(DEPTH - 1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wcnt          <= '0;
        end else begin
          wcnt <= wcnt + 3'd1;
        end
      end
    end
  end

  // Word storage, no reset needed: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_bank][wcnt] <= v_data;
  end

endmodule

// File: rtl/tt_ternary_host_seq.sv
// Host sequencer: resets the chip, loads weights, streams frames in step with the chip count.
module tt_ternary_host_seq #(
  parameter int IN_LEN     = 14,
  parameter int OUT_LEN    = 7,
  parameter int LOAD_WORDS = 14,
  parameter int RST_CYCLES = 2,
  parameter int OUT_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        w_wr,
  input  logic [15:0] w_data,
  input  logic        v_valid,
  output logic        v_ready,
  input  logic [15:0] v_data,
  output logic        chip_rst_n,
  output logic [7:0]  chip_ui_in,
  output logic [7:0]  chip_uio_in,
  input  logic [7:0]  chip_uo_out,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic [2:0]  res_row,
  output logic        res_last,
  output logic        busy,
  output logic        underrun
);
  import tt_ternary_pkg::*;

  localparam int WORDS = IN_LEN / 2;

  state_t      state, state_n;
  logic [3:0]  cnt, w_ptr, lk;
  logic [15:0] wbuf [LOAD_WORDS];
  logic [7:0]  tmr;
  logic        start_ok, bnd, fend, iss, iss_q, stop_q, pop, favail, buf_wen;
  logic [15:0] rd_word, bus;
  tag_t        dly [OUT_LAT];

  assign bnd  = (cnt[2:0] == 3'd0);
  assign fend = (cnt[2:0] == 3'd6);
  // A write in the same cycle as start counts towards the completeness check.
  assign start_ok = (state == IDLE) && start &&
                    ((w_ptr == 4'(LOAD_WORDS)) || (w_wr && (w_ptr == 4'(LOAD_WORDS - 1))));
  // Frame issue is decided at the boundary and held for the rest of the frame.
  assign iss  = (state == MULT) && (bnd ? favail : iss_q);
  assign pop  = iss && fend;
  assign lk   = cnt[3] ? ({1'b0, cnt[2:0]} + 4'd7) : {1'b0, cnt[2:0]};

  assign chip_ui_in  = bus[15:8];
  assign chip_uio_in = bus[7:0];

  tt_ternary_frame_buf #(.DEPTH(WORDS)) u_fbuf (
    .clk(clk), .rst(rst), .clr(start_ok), .wr_en(buf_wen),
    .v_valid(v_valid), .v_ready(v_ready), .v_data(v_data),
    .rd_idx(cnt[2:0]), .rd_data(rd_word),
    .frame_avail(favail), .pop_frame(pop)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = RSTC;
      RSTC:    if (tmr == 8'(RST_CYCLES - 1)) state_n = LOAD;
      LOAD:    if (cnt == 4'd14) state_n = MULT;
      MULT:    if (fend && stop_q) state_n = DRAIN;
      DRAIN:   if (tmr == 8'(OUT_LAT - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode: bus mux, buffer write enable, busy.
  always_comb begin
    busy    = (state != IDLE);
    buf_wen = (state == RSTC) || (state == LOAD) || (state == MULT);
    bus     = '0;
    case (state)
      LOAD:    bus = wbuf[lk];
      MULT:    if (iss) bus = rd_word;
      default: bus = '0;
    endcase
  end

  // Dwell timer for RSTC and DRAIN, restarted on every state change.
  always_ff @(posedge clk) begin
    if (rst || (state != state_n)) tmr <= '0;
    else                           tmr <= tmr + 8'd1;
  end

  // Chip reset, mirror count, weight pointer, stop latch, frame-issue hold, underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_rst_n <= 1'b0;
      cnt        <= '0;
      w_ptr      <= '0;
      iss_q      <= 1'b0;
      stop_q     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (start_ok)                                  chip_rst_n <= 1'b0;
      else if ((state == RSTC) && (state_n == LOAD)) chip_rst_n <= 1'b1;
      cnt   <= chip_rst_n ? next_cnt(cnt) : 4'd0;
      iss_q <= iss;
      if (state != MULT) stop_q <= 1'b0;
      else if (stop)     stop_q <= 1'b1;
      if (state == DRAIN) w_ptr <= '0;
      else if ((state == IDLE) && w_wr && (w_ptr != 4'(LOAD_WORDS))) w_ptr <= w_ptr + 4'd1;
      if (start_ok)                           underrun <= 1'b0;
      else if ((state == MULT) && bnd && !favail) underrun <= 1'b1;
    end
  end

  // Weight storage survives reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && w_wr && (w_ptr != 4'(LOAD_WORDS))) wbuf[w_ptr] <= w_data;
  end

  // Tag delay line matching chip latency, then registered result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_LAT; i++) dly[i] <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_last  <= 1'b0;
    end else begin
      dly[0] <= {iss, cnt[2:0]};
      for (int i = 1; i < OUT_LAT; i++) dly[i] <= dly[i-1];
      res_valid <= dly[OUT_LAT-1].v;
      res_last  <= dly[OUT_LAT-1].v && (dly[OUT_LAT-1].row == 3'(OUT_LEN - 1));
      if (dly[OUT_LAT-1].v) begin
        res_data <= chip_uo_out;
        res_row  <= dly[OUT_LAT-1].row;
      end
    end
  end

endmodule

// File: tb/tb_tt_ternary_host_seq.sv
// Directed bench for the host sequencer against a small stand-in chip model.
module tb_tt_ternary_host_seq;
  import tt_ternary_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, w_wr = 1'b0, v_valid = 1'b0;
  logic [15:0] w_data = '0, v_data = '0;
  logic        v_ready, chip_rst_n, res_valid, res_last, busy, underrun;
  logic [7:0]  chip_ui_in, chip_uio_in, chip_uo_out, res_data;
  logic [2:0]  res_row;
  logic [15:0] bus_w;
  int checks = 0, failures = 0;
  int nres = 0, nlast = 0;

  typedef struct { logic [2:0] row; logic [7:0] data; } exp_t;
  exp_t        expq[$];
  logic [15:0] vq[$];
  exp_t        e_c;
  logic        acc = 1'b0;

  always #5 clk = ~clk;
  assign bus_w = {chip_ui_in, chip_uio_in};

  tt_ternary_host_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .w_wr(w_wr), .w_data(w_data), .v_valid(v_valid), .v_ready(v_ready), .v_data(v_data),
    .chip_rst_n(chip_rst_n), .chip_ui_in(chip_ui_in), .chip_uio_in(chip_uio_in),
    .chip_uo_out(chip_uo_out), .res_valid(res_valid), .res_data(res_data),
    .res_row(res_row), .res_last(res_last), .busy(busy), .underrun(underrun)
  );

  // Stand-in chip with all weights +1: result = sum of the two elements plus the row count.
  function automatic logic [7:0] chip_f(input logic [15:0] w, input logic [2:0] r);
    return w[15:8] + w[7:0] + {5'b0, r};
  endfunction

  logic [3:0] ccnt = '0;
  logic [7:0] uo = '0;
  always @(posedge clk) begin
    if (!chip_rst_n) begin ccnt <= '0; uo <= '0; end
    else begin ccnt <= next_cnt(ccnt); uo <= chip_f(bus_w, ccnt[2:0]); end
  end
  assign chip_uo_out = uo;

  function automatic logic [15:0] frame_word(input int f, input int r);
    if (f == 0) return 16'h0101;
    return {8'(r + 1), 8'(3 * r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int f);
    exp_t e;
    for (int r = 0; r < 7; r++) begin
      vq.push_back(frame_word(f, r));
      e.row  = 3'(r);
      e.data = chip_f(frame_word(f, r), 3'(r));
      expq.push_back(e);
    end
  endtask

  task automatic drive_v();
    if (vq.size() > 0 && v_ready === 1'b1) begin v_valid = 1'b1; v_data = vq[0]; acc = 1'b1; end
    else begin v_valid = 1'b0; acc = 1'b0; end
  endtask

  task automatic tick();
    @(posedge clk);
    if (acc) void'(vq.pop_front());
    acc = 1'b0;
    #1;
    drive_v();
  endtask

  // Every result strobe is matched in order against the expected stream.
  always @(negedge clk) begin
    if (!rst && res_valid === 1'b1) begin
      nres++;
      if (res_last) nlast++;
      if (expq.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        e_c = expq.pop_front();
        chk("res_row", res_row, e_c.row);
        chk("res_data", res_data, e_c.data);
        chk("res_last", res_last, e_c.row == 3'd6);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rl, k, nbub;
    chk("model_lit_r0", chip_f(16'h0101, 3'd0), 8'd2);
    chk("model_lit_r6", chip_f(16'h0101, 3'd6), 8'd8);
    chk("model_lit_c2", chip_f(frame_word(1, 2), 3'd2), 8'd11);

    rst = 1'b1; repeat (3) tick();
    chk("rst_chip_rst_n", chip_rst_n, 0);
    chk("rst_bus", bus_w, 0);
    chk("rst_v_ready", v_ready, 0);
    chk("rst_res", {res_valid, res_data, res_row, res_last}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0; tick();

    for (int i = 0; i < 13; i++) begin w_wr = 1'b1; w_data = 16'(i + 1); tick(); end
    w_wr = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_w13_busy", busy, 0);
    w_wr = 1'b1; w_data = 16'd14; tick(); w_wr = 1'b0;

    push_frame(0); push_frame(0); drive_v();
    start = 1'b1; tick(); start = 1'b0;
    chk("rstc_busy", busy, 1);
    rl = 0;
    for (k = 0; k < 20 && chip_rst_n !== 1'b1; k++) begin
      if (busy && !chip_rst_n) rl++;
      tick();
    end
    chk("rstc_len", rl, 2);
    chk("load_reached", chip_rst_n, 1);

    for (int i = 0; i < 14; i++) begin chk("load_bus", bus_w, 16'(i + 1)); tick(); end
    chk("mult_row0_bus", bus_w, 16'h0101);
    chk("prebuf_done", vq.size(), 0);
    tick(); chk("lat_m1", res_valid, 0);
    tick(); chk("lat_m2", res_valid, 1);
    repeat (11) tick();
    chk("underrun_pre", underrun, 0);
    tick();
    chk("bubble_bus", bus_w, 0);
    push_frame(1); drive_v();
    nbub = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i <= 6) chk("bubble_bus", bus_w, 0);
      if (i == 1) chk("underrun_set", underrun, 1);
      if (i >= 2 && res_valid) nbub++;
      if (i == 7) chk("frame3_row0_bus", bus_w, frame_word(1, 0));
    end
    chk("bubble_no_res", nbub, 0);

    tick(); stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();
    chk("row6_after_stop_bus", bus_w, frame_word(1, 6));
    chk("row6_after_stop_busy", busy, 1);
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_bus", bus_w, 0);
    tick();
    chk("idle_after_drain", busy, 0);
    repeat (3) tick();
    chk("expq_empty", expq.size(), 0);
    chk("res_count", nres, 21);
    chk("last_count", nlast, 3);
    chk("underrun_sticky", underrun, 1);

    for (int i = 0; i < 14; i++) begin w_wr = 1'b1; w_data = 16'h0100 + 16'(i); tick(); end
    w_wr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("underrun_clr_start", underrun, 0);
    for (k = 0; k < 20 && chip_rst_n !== 1'b1; k++) tick();
    chk("load2_reached", chip_rst_n, 1);
    repeat (5) tick();
    chk("load2_beat5_bus", bus_w, 16'h0105);
    rst = 1'b1; tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_chip_rst_n", chip_rst_n, 0);
    chk("midrst_v_ready", v_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_bus", bus_w, 0);
    rst = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("midrst_wptr_cleared", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
